// File: rtl/contador_checker.sv
// contador_checker: on-line checker for the 4-bit multi-mode counter.
// From the counter's sampled inputs and its pre-edge Q, it predicts the next
// Q/rco/load, then compares that prediction one edge later.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset/clr; next edge only primes the prediction
// CHECKING | compare stored prediction every edge, then re-predict
// HALTED   | STOP_ON_ERROR hit; counts frozen until reset/clr
module contador_checker #(
  parameter int ERR_W         = 8,
  parameter int CNT_W         = 16,
  parameter bit STOP_ON_ERROR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             rco,
  input  logic             load,
  output logic             error,
  output logic             error_sticky,
  output logic [2:0]       err_code,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CHECKING = 2'b01,
    HALTED   = 2'b10
  } state_t;

  state_t     st;
  logic [3:0] exp_q;
  logic       exp_rco;
  logic       exp_load;
  logic       exp_valid;

  logic [3:0] pred_q;
  logic       pred_rco;
  logic       pred_load;
  logic [2:0] mm;

  // Golden counter model, always re-based on the observed Q so one fault
  // produces exactly one mismatch.
  always_comb begin
    pred_q    = Q;
    pred_rco  = 1'b0;
    pred_load = 1'b0;
    if (enable) begin
      case (mode)
        2'b00: begin
          pred_q   = Q + 4'd3;
          pred_rco = (Q >= 4'd13);
        end
        2'b01: begin
          pred_q   = Q - 4'd1;
          pred_rco = (Q == 4'd0);
        end
        2'b10: begin
          pred_q   = Q + 4'd1;
          pred_rco = (Q == 4'd15);
        end
        default: begin
          pred_q    = D;
          pred_load = 1'b1;
        end
      endcase
    end
  end

  // Per-field mismatch: bit2 = Q, bit1 = rco, bit0 = load.
  assign mm = {(Q != exp_q), (rco != exp_rco), (load != exp_load)};

  assign state = st;

  // Checker FSM with registered outputs; reset > clr > normal operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      exp_q        <= 4'd0;
      exp_rco      <= 1'b0;
      exp_load     <= 1'b0;
      exp_valid    <= 1'b0;
      error        <= 1'b0;
      error_sticky <= 1'b0;
      err_code     <= 3'b000;
      err_count    <= '0;
      check_count  <= '0;
    end else if (clr) begin
      st           <= IDLE;
      exp_q        <= 4'd0;
      exp_rco      <= 1'b0;
      exp_load     <= 1'b0;
      exp_valid    <= 1'b0;
      error        <= 1'b0;
      error_sticky <= 1'b0;
      err_code     <= 3'b000;
      err_count    <= '0;
      check_count  <= '0;
    end else begin
      case (st)
        IDLE: begin
          exp_q     <= pred_q;
          exp_rco   <= pred_rco;
          exp_load  <= pred_load;
          exp_valid <= 1'b1;
          error     <= 1'b0;
          st        <= CHECKING;
        end
        CHECKING: begin
          error <= exp_valid && (|mm);
          if (exp_valid) begin
            if (check_count != {CNT_W{1'b1}})
              check_count <= check_count + CNT_W'(1);
            if (|mm) begin
              err_code     <= mm;
              error_sticky <= 1'b1;
              if (err_count != {ERR_W{1'b1}})
                err_count <= err_count + ERR_W'(1);
              if (STOP_ON_ERROR)
                st <= HALTED;
            end
          end
          exp_q     <= pred_q;
          exp_rco   <= pred_rco;
          exp_load  <= pred_load;
          exp_valid <= 1'b1;
        end
        HALTED: begin
          error     <= 1'b0;
          exp_valid <= 1'b0;
        end
        default: begin
          st        <= IDLE;
          error     <= 1'b0;
          exp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_checker.sv
// Directed bench for contador_checker: a behavioural counter drives Q/rco/load
// (with optional per-field corruption) into three checker instances:
// default, STOP_ON_ERROR=1, and ERR_W=2.
module tb_contador_checker;

  logic       clk = 1'b0;
  logic       reset, clr, enable;
  logic [1:0] mode;
  logic [3:0] D, Q;
  logic       rco, load;

  logic        error0, sticky0;
  logic [2:0]  code0;
  logic [7:0]  ecnt0;
  logic [15:0] ccnt0;
  logic [1:0]  state0;

  logic        error1, sticky1;
  logic [2:0]  code1;
  logic [7:0]  ecnt1;
  logic [15:0] ccnt1;
  logic [1:0]  state1;

  logic        error2, sticky2;
  logic [2:0]  code2;
  logic [1:0]  ecnt2;
  logic [15:0] ccnt2;
  logic [1:0]  state2;

  int tests = 0;
  int fails = 0;
  int errs_seen = 0;
  logic flip_q = 1'b0, flip_rco = 1'b0, flip_load = 1'b0;

  always #5 clk = ~clk;

  contador_checker dut0 (
    .clk(clk), .reset(reset), .clr(clr), .enable(enable), .mode(mode), .D(D),
    .Q(Q), .rco(rco), .load(load), .error(error0), .error_sticky(sticky0),
    .err_code(code0), .err_count(ecnt0), .check_count(ccnt0), .state(state0));

  contador_checker #(.STOP_ON_ERROR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .enable(enable), .mode(mode), .D(D),
    .Q(Q), .rco(rco), .load(load), .error(error1), .error_sticky(sticky1),
    .err_code(code1), .err_count(ecnt1), .check_count(ccnt1), .state(state1));

  contador_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .clr(clr), .enable(enable), .mode(mode), .D(D),
    .Q(Q), .rco(rco), .load(load), .error(error2), .error_sticky(sticky2),
    .err_code(code2), .err_count(ecnt2), .check_count(ccnt2), .state(state2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One counter edge: compute the correct update, then drive it (optionally corrupted).
  task automatic tick();
    logic [3:0] nq;
    logic nr, nl;
    nq = Q; nr = 1'b0; nl = 1'b0;
    if (enable) begin
      case (mode)
        2'b00: begin nq = Q + 4'd3; nr = (Q >= 4'd13); end
        2'b01: begin nq = Q - 4'd1; nr = (Q == 4'd0); end
        2'b10: begin nq = Q + 4'd1; nr = (Q == 4'd15); end
        default: begin nq = D; nl = 1'b1; end
      endcase
    end
    @(posedge clk);
    #1;
    Q    = nq ^ (flip_q ? 4'h3 : 4'h0);
    rco  = nr ^ flip_rco;
    load = nl ^ flip_load;
    if (error0) errs_seen++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clr = 1'b0; enable = 1'b0; mode = 2'b00; D = 4'd0;
    Q = 4'd0; rco = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_error", error0, 0);
    check("rst_sticky", sticky0, 0);
    check("rst_code", code0, 0);
    check("rst_errcnt", ecnt0, 0);
    check("rst_chkcnt", ccnt0, 0);
    check("rst_state", state0, 0);

    // 1: mode 10 correct counting for 20 edges
    enable = 1'b1; mode = 2'b10;
    reset = 1'b0;
    errs_seen = 0;
    repeat (20) tick();
    check("t1_no_error", errs_seen, 0);
    check("t1_chkcnt", ccnt0, 19);
    check("t1_state", state0, 1);
    check("t1_chkcnt_w2", ccnt2, 19);

    // 2: mode 00 from 12: 15, 2 (rco), then corrupt 5 -> 6
    mode = 2'b11; D = 4'd12;
    tick();
    mode = 2'b00;
    tick();
    check("t2_rco_no_wrap", rco, 0);
    tick();
    check("t2_rco_wrap", rco, 1);
    check("t2_no_err_wrap", error0, 0);
    flip_q = 1'b1;
    tick();
    flip_q = 1'b0;
    check("t2_q_forced", Q, 6);
    check("t2_not_yet", error0, 0);
    tick();
    check("t2_error", error0, 1);
    check("t2_code", code0, 3'b100);
    check("t2_errcnt", ecnt0, 1);
    check("t2_stop_state", state1, 2);
    check("t2_stop_chkcnt", ccnt1, 24);
    tick();
    check("t2_rebased", error0, 0);
    check("t2_code_held", code0, 3'b100);

    // 3: mode 01 from 0 with rco lost, then load lost in mode 11
    mode = 2'b11; D = 4'd0;
    tick();
    mode = 2'b01;
    flip_rco = 1'b1;
    tick();
    flip_rco = 1'b0;
    tick();
    check("t3_rco_error", error0, 1);
    check("t3_rco_code", code0, 3'b010);
    check("t3_sticky", sticky0, 1);
    check("t3_errcnt", ecnt0, 2);
    mode = 2'b11; D = 4'd9;
    flip_load = 1'b1;
    tick();
    flip_load = 1'b0;
    tick();
    check("t3_load_code", code0, 3'b001);
    check("t3_load_errcnt", ecnt0, 3);
    check("t3_w2_errcnt", ecnt2, 3);
    check("t3_stop_errcnt", ecnt1, 1);
    check("t3_stop_state", state1, 2);
    check("t3_stop_chkcnt", ccnt1, 24);
    check("t3_stop_error", error1, 0);
    check("t3_stop_code", code1, 3'b100);

    // 4: clr pulse returns everything to IDLE
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_state", state0, 0);
    check("t4_chkcnt", ccnt0, 0);
    check("t4_errcnt", ecnt0, 0);
    check("t4_sticky", sticky0, 0);
    check("t4_code", code0, 0);
    check("t4_stop_state", state1, 0);
    check("t4_stop_errcnt", ecnt1, 0);
    tick();
    check("t4_prime_state", state0, 1);
    check("t4_prime_chkcnt", ccnt0, 0);
    check("t4_stop_resume", state1, 1);
    tick();
    check("t4_first_cmp", ccnt0, 1);

    // clr coinciding with a mismatch: clear wins
    flip_q = 1'b1;
    tick();
    flip_q = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_win_error", error0, 0);
    check("clr_win_errcnt", ecnt0, 0);
    check("clr_win_sticky", sticky0, 0);

    // 5: five mismatches; ERR_W=2 saturates at 3
    mode = 2'b10;
    tick();
    flip_q = 1'b1;
    repeat (5) tick();
    flip_q = 1'b0;
    tick();
    check("t5_errcnt", ecnt0, 5);
    check("t5_w2_sat", ecnt2, 3);
    check("t5_w2_sticky", sticky2, 1);
    check("t5_stop_errcnt", ecnt1, 1);
    check("t5_stop_state", state1, 2);

    // 6: asynchronous reset mid-cycle during CHECKING
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_state", state0, 0);
    check("t6_async_chkcnt", ccnt0, 0);
    check("t6_async_errcnt", ecnt0, 0);
    check("t6_async_sticky", sticky0, 0);
    Q = 4'd0; rco = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();
    check("t6_prime_chkcnt", ccnt0, 0);
    check("t6_prime_state", state0, 1);
    tick();
    check("t6_cmp_chkcnt", ccnt0, 1);
    check("t6_cmp_error", error0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
